uart_host_bridge: RTL and testbench

- Host-side initiator for the COREUART_C0 CPU port: drives CSN/WEN/OEN and DATA_IN, and monitors TXRDY, RXRDY, DATA_OUT and the status flags.
- Converts the UART's polled strobe interface into two byte streams with valid/ready handshakes, one for TX and one for RX.
- Sits between the LCD/camera control logic and the UART core.
- Provides a 1-entry TX holding register, a 2-entry RX buffer with error tags, fair arbitration between reads and writes, and a saturating overflow counter.

---
 rtl/uart_host_bridge.sv | 175 +++++++++++++++++
 tb/tb_uart_host_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_bridge.sv
// Host-side initiator for the COREUART_C0 CPU port. It turns the UART's polled
// strobe interface into a TX and an RX byte stream with valid/ready handshakes.
module uart_host_bridge #(
    parameter int WR_GUARD  = 3,
    parameter int RD_GUARD  = 3,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [7:0]           TX_DATA,
    input  logic                 TX_VALID,
    output logic                 TX_READY,
    output logic [7:0]           RX_DATA,
    output logic                 RX_PERR,
    output logic                 RX_FERR,
    output logic                 RX_VALID,
    input  logic                 RX_READY,
    output logic                 CSN,
    output logic                 WEN,
    output logic                 OEN,
    output logic [7:0]           UART_DIN,
    input  logic [7:0]           UART_DOUT,
    input  logic                 TXRDY,
    input  logic                 RXRDY,
    input  logic                 PARITY_ERR,
    input  logic                 FRAMING_ERR,
    input  logic                 OVERFLOW,
    output logic [OVF_CNT_W-1:0] OVF_CNT
);

    // Handshakes: a byte moves on a rising CLK edge where its valid and ready
    // are both high; valid holds its data stable until that edge.

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_WAIT,
        S_RD,
        S_RD_WAIT
    } state_t;

    localparam int GW = 8;

    state_t         state, state_next;
    logic [GW-1:0]  guard_cnt, guard_next;
    logic           last_rx;
    logic           wr_req, rd_req;

    logic           hold_full;
    logic [7:0]     hold_data;
    logic           tx_accept;

    logic [9:0]     rx_mem [2];
    logic           rx_wr_ptr, rx_rd_ptr;
    logic [1:0]     rx_count;
    logic           rx_push, rx_pop;

    logic           csn, wen, oen;
    logic [7:0]     uart_din;

    logic           ovf_s, ovf_d;
    logic [OVF_CNT_W-1:0] ovf_cnt;

    assign TX_READY  = !hold_full;
    assign tx_accept = TX_VALID && TX_READY;
    assign RX_VALID  = (rx_count != 2'd0);
    assign rx_pop    = RX_VALID && RX_READY;
    assign rx_push   = (state == S_RD);
    assign {RX_PERR, RX_FERR, RX_DATA} = rx_mem[rx_rd_ptr];
    assign CSN       = csn;
    assign WEN       = wen;
    assign OEN       = oen;
    assign UART_DIN  = uart_din;
    assign OVF_CNT   = ovf_cnt;

    always_comb begin
        state_next = state;
        guard_next = guard_cnt;
        wr_req     = hold_full && TXRDY;
        rd_req     = RXRDY && (rx_count < 2'd2);
        case (state)
            S_IDLE: begin
                // On contention the side not served last time wins.
                if (wr_req && rd_req) state_next = last_rx ? S_WR : S_RD;
                else if (wr_req)      state_next = S_WR;
                else if (rd_req)      state_next = S_RD;
            end
            S_WR: begin
                state_next = S_WR_WAIT;
                guard_next = '0;
            end
            S_WR_WAIT: begin
                if (guard_cnt >= GW'(WR_GUARD - 1)) state_next = S_IDLE;
                else                                guard_next = guard_cnt + GW'(1);
            end
            S_RD: begin
                state_next = S_RD_WAIT;
                guard_next = '0;
            end
            S_RD_WAIT: begin
                if (guard_cnt >= GW'(RD_GUARD - 1)) state_next = S_IDLE;
                else                                guard_next = guard_cnt + GW'(1);
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they come straight off flops.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            guard_cnt <= '0;
            last_rx   <= 1'b0;
            csn       <= 1'b1;
            wen       <= 1'b1;
            oen       <= 1'b1;
            uart_din  <= '0;
        end else begin
            state     <= state_next;
            guard_cnt <= guard_next;
            if (state == S_WR) last_rx <= 1'b0;
            if (state == S_RD) last_rx <= 1'b1;
            csn <= !((state_next == S_WR) || (state_next == S_RD));
            wen <= !(state_next == S_WR);
            oen <= !(state_next == S_RD);
            if (state_next == S_WR) uart_din <= hold_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (tx_accept) begin
            hold_full <= 1'b1;
            hold_data <= TX_DATA;
        end else if (state == S_WR) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 2; i++) rx_mem[i] <= '0;
            rx_wr_ptr <= 1'b0;
            rx_rd_ptr <= 1'b0;
            rx_count  <= 2'd0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr_ptr] <= {PARITY_ERR, FRAMING_ERR, UART_DOUT};
                rx_wr_ptr         <= !rx_wr_ptr;
            end
            if (rx_pop) rx_rd_ptr <= !rx_rd_ptr;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 2'd1;
                2'b01:   rx_count <= rx_count - 2'd1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // OVERFLOW is sampled once, then edge-detected against its delayed copy.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ovf_s   <= 1'b0;
            ovf_d   <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            ovf_s <= OVERFLOW;
            ovf_d <= ovf_s;
            if (ovf_s && !ovf_d && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed bench for uart_host_bridge: table of single TX/RX transfers plus
// hand-written sequences for reset, arbitration, back-pressure and overflow.
module tb_uart_host_bridge;

    localparam int WR_GUARD = 3;
    localparam int RD_GUARD = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_perr, rx_ferr, rx_valid, rx_ready;
    logic       csn, wen, oen;
    logic [7:0] uart_din, uart_dout;
    logic       txrdy, rxrdy, parity_err, framing_err, overflow;
    logic [7:0] ovf_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        bit is_rd;
        int cyc;
    } ev_t;
    ev_t ev_q[$];
    bit  prev_strobe = 1'b0;

    typedef struct {
        bit         is_rd;
        logic [7:0] din;
        bit         perr;
        bit         ferr;
        logic [7:0] exp_byte;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;
    vec_t vecs[6];

    uart_host_bridge #(.WR_GUARD(WR_GUARD), .RD_GUARD(RD_GUARD), .OVF_CNT_W(8)) dut (
        .CLK(clk), .RESET_N(rst_n),
        .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
        .RX_DATA(rx_data), .RX_PERR(rx_perr), .RX_FERR(rx_ferr),
        .RX_VALID(rx_valid), .RX_READY(rx_ready),
        .CSN(csn), .WEN(wen), .OEN(oen), .UART_DIN(uart_din), .UART_DOUT(uart_dout),
        .TXRDY(txrdy), .RXRDY(rxrdy), .PARITY_ERR(parity_err), .FRAMING_ERR(framing_err),
        .OVERFLOW(overflow), .OVF_CNT(ovf_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobe(input bit rd, input int limit, input string name, output int waited);
        waited = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if ((rd ? oen : wen) == 1'b0) begin
                waited = i;
                break;
            end
        end
        if (waited < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no strobe within %0d cycles, expected one", name, limit);
        end
    endtask

    // Strobe monitor: exclusivity, chip select tracking, single-cycle width.
    always @(negedge clk) begin
        chk("csn_vs_strobes", csn, wen & oen);
        if (!wen || !oen) begin
            chk("strobe_excl", wen | oen, 1);
            chk("strobe_width", prev_strobe, 0);
            if (rst_n) ev_q.push_back('{is_rd: !oen, cyc: cyc});
        end
        prev_strobe = !wen || !oen;
    end

    task automatic do_write(input logic [7:0] data, input logic [7:0] exp_din);
        int w;
        int n0;
        tx_data  = data;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("tx_ready_after_accept", tx_ready, 0);
        wait_strobe(1'b0, 20, "wr_strobe", w);
        if (w < 0) return;
        chk("wr_latency", w, 1);
        chk("wr_din", uart_din, exp_din);
        chk("wr_oen_high", oen, 1);
        tick();
        chk("wr_wen_release", wen, 1);
        chk("tx_ready_after_wr", tx_ready, 1);
        n0 = ev_q.size();
        tick(WR_GUARD);
        chk("wr_guard_quiet", ev_q.size(), n0);
    endtask

    task automatic do_read(input logic [7:0] data, input bit perr, input bit ferr,
                           input logic [7:0] exp_byte, input bit exp_perr, input bit exp_ferr);
        int w;
        uart_dout   = data;
        parity_err  = perr;
        framing_err = ferr;
        rxrdy       = 1'b1;
        wait_strobe(1'b1, 20, "rd_strobe", w);
        rxrdy = 1'b0;
        if (w < 0) return;
        chk("rd_latency", w, 1);
        chk("rd_wen_high", wen, 1);
        tick();
        chk("rd_oen_release", oen, 1);
        chk("rd_valid", rx_valid, 1);
        chk("rd_data", rx_data, exp_byte);
        chk("rd_perr", rx_perr, exp_perr);
        chk("rd_ferr", rx_ferr, exp_ferr);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("rd_popped", rx_valid, 0);
        tick(RD_GUARD);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        vecs[0] = '{is_rd: 1'b0, din: 8'hA5, perr: 1'b0, ferr: 1'b0, exp_byte: 8'hA5, exp_perr: 1'b0, exp_ferr: 1'b0};
        vecs[1] = '{is_rd: 1'b1, din: 8'h3C, perr: 1'b1, ferr: 1'b0, exp_byte: 8'h3C, exp_perr: 1'b1, exp_ferr: 1'b0};
        vecs[2] = '{is_rd: 1'b0, din: 8'h00, perr: 1'b0, ferr: 1'b0, exp_byte: 8'h00, exp_perr: 1'b0, exp_ferr: 1'b0};
        vecs[3] = '{is_rd: 1'b1, din: 8'hFF, perr: 1'b0, ferr: 1'b1, exp_byte: 8'hFF, exp_perr: 1'b0, exp_ferr: 1'b1};
        vecs[4] = '{is_rd: 1'b0, din: 8'h5A, perr: 1'b0, ferr: 1'b0, exp_byte: 8'h5A, exp_perr: 1'b0, exp_ferr: 1'b0};
        vecs[5] = '{is_rd: 1'b1, din: 8'h81, perr: 1'b1, ferr: 1'b1, exp_byte: 8'h81, exp_perr: 1'b1, exp_ferr: 1'b1};

        // Reset held with requests pending.
        rst_n = 1'b0; tx_data = 8'h11; tx_valid = 1'b1; rx_ready = 1'b0;
        uart_dout = 8'h00; txrdy = 1'b1; rxrdy = 1'b1;
        parity_err = 1'b0; framing_err = 1'b0; overflow = 1'b0;
        tick(2);
        chk("rst_csn", csn, 1);
        chk("rst_wen", wen, 1);
        chk("rst_oen", oen, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", {rx_perr, rx_ferr, rx_data}, 0);
        chk("rst_uart_din", uart_din, 0);
        chk("rst_ovf_cnt", ovf_cnt, 0);
        tx_valid = 1'b0;
        rxrdy    = 1'b0;
        rst_n    = 1'b1;
        tick(4);
        chk("post_rst_quiet", ev_q.size(), 0);

        foreach (vecs[i]) begin
            if (vecs[i].is_rd)
                do_read(vecs[i].din, vecs[i].perr, vecs[i].ferr,
                        vecs[i].exp_byte, vecs[i].exp_perr, vecs[i].exp_ferr);
            else
                do_write(vecs[i].din, vecs[i].exp_byte);
        end

        // Arbitration: both sides requesting continuously.
        parity_err = 1'b0; framing_err = 1'b0;
        tick(2);
        ev_q.delete();
        rx_ready = 1'b1; tx_data = 8'h40; tx_valid = 1'b1; uart_dout = 8'h99; rxrdy = 1'b1;
        for (int i = 0; i < 100 && ev_q.size() < 6; i++) tick();
        tx_valid = 1'b0;
        rxrdy    = 1'b0;
        chk("arb_events", ev_q.size() >= 6, 1);
        if (ev_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("arb_order", ev_q[i].is_rd, (i % 2 == 0));
                if (i > 0) chk("arb_gap", ev_q[i].cyc - ev_q[i-1].cyc, 5);
            end
        end
        tick(20);
        rx_ready = 1'b0;
        chk("arb_drained", rx_valid, 0);

        // Back-pressure: two buffered reads block the third.
        ev_q.delete();
        for (int k = 0; k < 2; k++) begin
            uart_dout = 8'(k + 1);
            rxrdy     = 1'b1;
            wait_strobe(1'b1, 20, "bp_rd", w);
            rxrdy = 1'b0;
            tick(5);
        end
        uart_dout = 8'h03;
        rxrdy     = 1'b1;
        tick(10);
        chk("bp_withheld", ev_q.size(), 2);
        chk("bp_oen_high", oen, 1);
        chk("bp_valid", rx_valid, 1);
        chk("bp_head0", rx_data, 8'h01);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("bp_head1", rx_data, 8'h02);
        wait_strobe(1'b1, 10, "bp_resume", w);
        rxrdy = 1'b0;
        tick();
        chk("bp_head1_again", rx_data, 8'h02);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("bp_head2", rx_data, 8'h03);
        chk("bp_valid2", rx_valid, 1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("bp_empty", rx_valid, 0);
        tick(4);

        // Overflow counting: a long level counts once, then saturation.
        overflow = 1'b1;
        tick(10);
        overflow = 1'b0;
        tick(3);
        chk("ovf_level", ovf_cnt, 1);
        repeat (100) begin overflow = 1'b1; tick(); overflow = 1'b0; tick(); end
        tick(3);
        chk("ovf_101", ovf_cnt, 101);
        repeat (200) begin overflow = 1'b1; tick(); overflow = 1'b0; tick(); end
        tick(3);
        chk("ovf_sat", ovf_cnt, 255);

        // Reset in the middle of a write with an RX entry buffered.
        uart_dout = 8'h77;
        rxrdy     = 1'b1;
        wait_strobe(1'b1, 20, "rst_op_rd", w);
        rxrdy = 1'b0;
        tick(5);
        chk("rst_op_rx_valid", rx_valid, 1);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        wait_strobe(1'b0, 20, "rst_op_wr", w);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_op_wen", wen, 1);
        chk("rst_op_csn", csn, 1);
        chk("rst_op_tx_ready", tx_ready, 1);
        chk("rst_op_rx_empty", rx_valid, 0);
        chk("rst_op_ovf", ovf_cnt, 0);
        tick();
        ev_q.delete();
        rst_n = 1'b1;
        tick(6);
        chk("rst_op_dropped", ev_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
